// File: rtl/score_display_mux.sv
// rtl/score_display_mux.sv - multiplexed 7-segment score display driver; optional macro SCORE_DISP_LZB_EN enables leading-zero blanking
module score_display_mux #(
    parameter int NDIGITS     = 4,
    parameter int SCORE_W     = 20,
    parameter int SHIFT       = 6,
    parameter int REFRESH_DIV = 4,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hi,
    input  logic [SCORE_W-1:0] score,
    input  logic [SCORE_W-1:0] highest,
    output logic [7:0]         seg,
    output logic [NDIGITS-1:0] an,
    output logic               busy,
    output logic               overflow
);
    localparam int BW  = SCORE_W - SHIFT;
    localparam int DW  = 4 * NDIGITS;
    localparam int IW  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BCW = $clog2(BW + 1);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Largest value the digits can show: 10^NDIGITS - 1
    function automatic logic [63:0] max_disp();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < NDIGITS; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = max_disp();

    // Segment pattern for one BCD digit in board polarity; codes above 9 are blank
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'hC0;
            4'd1:    g = 8'hF9;
            4'd2:    g = 8'hA4;
            4'd3:    g = 8'hB0;
            4'd4:    g = 8'h99;
            4'd5:    g = 8'h92;
            4'd6:    g = 8'h82;
            4'd7:    g = 8'hF8;
            4'd8:    g = 8'h80;
            4'd9:    g = 8'h90;
            default: g = 8'hFF;
        endcase
        return (ACTIVE_LOW != 0) ? g : ~g;
    endfunction

    // One-hot digit enable in board polarity
    function automatic logic [NDIGITS-1:0] an_code(input logic [IW-1:0] i);
        logic [NDIGITS-1:0] oh;
        oh = NDIGITS'(1) << i;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    logic [1:0]         state;
    logic [BW-1:0]      bin;
    logic [DW-1:0]      bcd;
    logic [DW-1:0]      bcd_adj;
    logic [BCW-1:0]     bit_cnt;
    logic               ovf_n;
    logic [DW-1:0]      disp;
    logic [SCORE_W-1:0] sel_val;
    logic [BW-1:0]      scaled;
    logic [BW-1:0]      load_val;
    logic               load_ovf;

    // Select, scale and saturate the value captured at the start of a frame
    always_comb begin
        sel_val  = hi ? highest : score;
        scaled   = BW'(sel_val >> SHIFT);
        load_ovf = ({{(64-BW){1'b0}}, scaled} > MAXV);
        load_val = load_ovf ? MAXV[BW-1:0] : scaled;
    end

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < NDIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Free-running converter: LOAD, BW shift cycles, then publish result atomically
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_LOAD;
            bin      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            ovf_n    <= 1'b0;
            disp     <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    bin     <= load_val;
                    ovf_n   <= load_ovf;
                    bcd     <= '0;
                    bit_cnt <= BCW'(BW);
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    bit_cnt    <= bit_cnt - 1'b1;
                    if (bit_cnt == BCW'(1)) state <= S_DONE;
                end
                S_DONE: begin
                    disp     <= bcd;
                    overflow <= ovf_n;
                    state    <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign busy = (state == S_SHIFT);

    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_nxt;
    logic [CW-1:0]      cnt;
    logic [3:0]         digit_nxt;
    logic               blank_nxt;
    logic [NDIGITS-1:0] lz;

`ifdef SCORE_DISP_LZB_EN
    logic zero_above;

    // Digit k>0 is a leading zero when it and every digit above it are zero
    always_comb begin
        zero_above = 1'b1;
        lz         = '0;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (disp[4*k +: 4] == 4'd0);
            if (k != 0) lz[k] = zero_above;
        end
    end
`else
    assign lz = '0;
`endif

    // Next digit to light and the disp nibble that goes with it
    always_comb begin
        idx_nxt   = (idx == IW'(NDIGITS - 1)) ? '0 : idx + 1'b1;
        digit_nxt = 4'd0;
        blank_nxt = 1'b0;
        for (int k = 0; k < NDIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                digit_nxt = disp[4*k +: 4];
                blank_nxt = lz[k];
            end
        end
    end

    // Scan timer: seg and an change together only when the digit advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            an  <= an_code(IW'(0));
            seg <= glyph(4'd0);
        end else if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt <= '0;
            idx <= idx_nxt;
            an  <= an_code(idx_nxt);
            seg <= blank_nxt ? glyph(4'hF) : glyph(digit_nxt);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_score_display_mux.sv
// tb/tb_score_display_mux.sv - self-checking bench for score_display_mux
`timescale 1ns/1ps
module tb_score_display_mux;
    localparam int ND = 4;
    localparam int SW = 20;
    localparam int SH = 6;
    localparam int RD = 4;
    localparam int BW = SW - SH;

    logic          clk = 1'b0;
    logic          rst;
    logic          hi;
    logic [SW-1:0] score;
    logic [SW-1:0] highest;
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic          busy;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    score_display_mux #(
        .NDIGITS(ND), .SCORE_W(SW), .SHIFT(SH), .REFRESH_DIV(RD), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .hi(hi), .score(score), .highest(highest),
        .seg(seg), .an(an), .busy(busy), .overflow(overflow)
    );

    typedef struct {
        logic [SW-1:0] score;
        logic [SW-1:0] highest;
        logic          hi;
        int            exp_v;
        logic          exp_ovf;
    } vec_t;

    vec_t       vt[10];
    logic [7:0] glyph_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int model_v(input logic [SW-1:0] s, input logic [SW-1:0] h,
                                   input logic sel, output logic ovf);
        int v;
        v   = int'((sel ? h : s) >> SH);
        ovf = (v > 9999);
        if (ovf) v = 9999;
        return v;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k);
        int p;
        p = 10 ** k;
`ifdef SCORE_DISP_LZB_EN
        if (k > 0 && v < p) return 8'hFF;
`endif
        return glyph_tab[(v / p) % 10];
    endfunction

    function automatic int an_idx(input logic [ND-1:0] a);
        int r;
        r = -1;
        for (int k = 0; k < ND; k++) if (a == ~(ND'(1) << k)) r = k;
        return r;
    endfunction

    task automatic wait_fall(input string name);
        bit seen1;
        int n;
        seen1 = 0;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (busy) seen1 = 1;
            else if (seen1) return;
            n++;
            if (n > 200) begin
                chk({name, " busy timeout"}, 0, 1);
                return;
            end
        end
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (busy) return;
            n++;
            if (n > 200) begin
                chk({name, " busy rise timeout"}, 0, 1);
                return;
            end
        end
    endtask

    task automatic check_frame(input logic [SW-1:0] s, input logic [SW-1:0] h, input logic sel,
                               input int ev, input logic eovf, input string name);
        logic [7:0] seen[ND];
        bit         got[ND];
        int         ix;
        @(negedge clk);
        score = s; highest = h; hi = sel;
        wait_fall(name);
        wait_fall(name);
        repeat (ND*RD + 2) @(negedge clk);
        for (int k = 0; k < ND; k++) begin got[k] = 0; seen[k] = 8'h00; end
        for (int c = 0; c < ND*RD; c++) begin
            @(negedge clk);
            ix = an_idx(an);
            if (ix >= 0) begin seen[ix] = seg; got[ix] = 1; end
        end
        for (int k = 0; k < ND; k++)
            chk($sformatf("%s seg digit%0d", name, k), got[k] ? {24'd0, seen[k]} : 32'hDEAD,
                {24'd0, exp_seg(ev, k)});
        chk($sformatf("%s overflow", name), {31'd0, overflow}, {31'd0, eovf});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ND-1:0] prev, oh, nxt;
        int            run;
        bit            first;
        logic          rovf;
        int            rv;
        logic [SW-1:0] rs, rh;
        logic          rsel;

        vt[0] = '{20'd64000,  20'd0,      1'b0, 1000, 1'b0};
        vt[1] = '{20'd64000,  20'd640,    1'b1, 10,   1'b0};
        vt[2] = '{20'hFFFFF,  20'd0,      1'b0, 9999, 1'b1};
        vt[3] = '{20'd0,      20'd0,      1'b0, 0,    1'b0};
        vt[4] = '{20'd448,    20'd0,      1'b0, 7,    1'b0};
        vt[5] = '{20'd639999, 20'd0,      1'b0, 9999, 1'b0};
        vt[6] = '{20'd640000, 20'd0,      1'b0, 9999, 1'b1};
        vt[7] = '{20'd0,      20'hFFFFF,  1'b1, 9999, 1'b1};
        vt[8] = '{20'd63,     20'd5000,   1'b0, 0,    1'b0};
        vt[9] = '{20'd19520,  20'd0,      1'b0, 305,  1'b0};

        rst = 1'b1; hi = 1'b0; score = '0; highest = '0;
        repeat (3) @(negedge clk);
        chk("reset seg", {24'd0, seg}, 32'hC0);
        chk("reset an", {28'd0, an}, 32'hE);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset overflow", {31'd0, overflow}, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            check_frame(vt[i].score, vt[i].highest, vt[i].hi, vt[i].exp_v, vt[i].exp_ovf,
                        $sformatf("vec%0d", i));

        // hi toggled during SHIFT must not change the frame already loaded
        @(negedge clk);
        score = 20'hFFFFF; highest = 20'd640; hi = 1'b1;
        wait_fall("hitog");
        wait_fall("hitog");
        wait_rise("hitog");
        hi = 1'b0;
        wait_fall("hitog");
        @(negedge clk);
        chk("hi toggle frame overflow", {31'd0, overflow}, 0);
        wait_fall("hitog");
        @(negedge clk);
        chk("hi after toggle overflow", {31'd0, overflow}, 1);

        // scan order and dwell time
        @(negedge clk);
        prev = an; run = 1; first = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (an !== prev) begin
                oh  = ~prev;
                nxt = ~{oh[ND-2:0], oh[ND-1]};
                chk("scan order", {28'd0, an}, {28'd0, nxt});
                if (!first) chk("scan dwell", run, RD);
                first = 0; prev = an; run = 1;
            end else begin
                run++;
            end
        end

        // reset in the middle of SHIFT
        @(negedge clk);
        score = 20'd64000; hi = 1'b0;
        wait_rise("rstmid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst busy", {31'd0, busy}, 0);
            chk("rst an", {28'd0, an}, 32'hE);
            chk("rst seg", {24'd0, seg}, 32'hC0);
        end
        rst = 1'b0;
        repeat (BW) @(negedge clk);
        chk("post-rst busy in shift", {31'd0, busy}, 1);
        @(negedge clk);
        chk("post-rst busy done", {31'd0, busy}, 0);
        check_frame(20'd64000, 20'd0, 1'b0, 1000, 1'b0, "post-rst");

        // randomized frames against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            rs   = (i % 2 == 0) ? SW'($urandom_range(0, 640100)) : SW'($urandom);
            rh   = SW'($urandom_range(0, 700000));
            rsel = 1'($urandom_range(0, 1));
            rv   = model_v(rs, rh, rsel, rovf);
            check_frame(rs, rh, rsel, rv, rovf, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
